host_bus_port: RTL and testbench
================================

# host_bus_port

Parametrised host-bus front end between the asynchronous external register bus and the internal register file. It synchronizes the bus signals with a configurable number of stages and posts writes into a small FIFO so a slow register side never loses a host write. Reads are a request/response handshake that stays ordered behind posted writes. DTACK is generated internally: held NAK until the write is queued or the read data is ready, and the read has an optional timeout.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for all bus inputs; legal values 2–4.
- `REG_W`, 4: register-number width.
- `DATA_W`, 8: bus data width.
- `FIFO_DEPTH`, 4: posted-write FIFO entries; power of 2, at least 2.
- `RD_TIMEOUT`, 15: cycles allowed in RD_WAIT before a forced completion; 0 disables the timeout.
- `clk` in 1: single clock; must be more than 2x the bus strobe rate.
- `reset_i` in 1: **asynchronous, active-high** reset.
- `bus_cs_n_i` in 1: chip select, active low, asynchronous.
- `bus_rd_nwr_i` in 1: 1 = read, 0 = write.
- `bus_reg_num_i` in REG_W: register number.
- `bus_bytesel_i` in 1: byte select.
- `bus_data_i` in DATA_W: write data.
- `bus_data_o` out DATA_W: read data.
- `bus_data_oe_o` out 1: data output enable.
- `bus_dtack_o` out 1: transfer acknowledge; `xv::DTACK_ACK` or `xv::DTACK_NAK`.
- `wr_valid_o` out 1: FIFO head is valid.
- `wr_ready_i` in 1: register side accepts the head.
- `wr_reg_num_o` out REG_W, `wr_bytesel_o` out 1, `wr_data_o` out DATA_W: FIFO head fields.
- `rd_req_o` out 1: one-cycle read request.
- `rd_reg_num_o` out REG_W, `rd_bytesel_o` out 1: read target; held stable while in RD_WAIT.
- `rd_valid_i` in 1: read data valid.
- `rd_data_i` in DATA_W: read data.
- `rd_timeout_o` out 1: one-cycle pulse on a read timeout.
- `fifo_level_o` out $clog2(FIFO_DEPTH+1): number of FIFO entries.

## Operation
- **Synchronizers:** each input passes through SYNC_STAGES flops; `cs_s` is the last stage, `cs_last` is `cs_s` delayed one cycle. All stages reset to `xv::CS_DISABLED` so reset cannot create a false edge.
- **Start edge:** `cs_last` is DISABLED and `cs_s` is ENABLED, sampled in IDLE. The synchronized rd_nwr, reg_num, bytesel and data are captured into a transaction register.
- **Release:** the first synchronizer stage shows CS DISABLED.
- **FSM states:** IDLE, WR_PUSH, RD_DRAIN, RD_WAIT, ACK.
- **IDLE:** on a start edge, go to WR_PUSH for a write or RD_DRAIN for a read.
- **WR_PUSH:** when the FIFO is not full, push the captured entry and go to ACK. While full, hold DTACK NAK (host wait state).
- **RD_DRAIN:** wait for the FIFO to be empty, including the last pop completing, so reads never overtake posted writes. Then assert `rd_req_o` for one cycle and go to RD_WAIT.
- **RD_WAIT:** on `rd_valid_i`, latch `rd_data_i` into `bus_data_o` and go to ACK. Note that `rd_req_o` is asserted in the RD_DRAIN exit cycle, so `rd_valid_i` can arrive no earlier than the cycle after `rd_req_o`.
- **Read timeout:** a counter counts cycles spent in RD_WAIT. When it reaches RD_TIMEOUT without `rd_valid_i`, latch all-ones into `bus_data_o`, pulse `rd_timeout_o`, and go to ACK. If `rd_valid_i` and expiry land in the same cycle, `rd_valid_i` wins.
- **ACK:** `bus_dtack_o` = ACK. `bus_data_oe_o` = 1 only for a read. On release, go to IDLE with DTACK NAK and OE 0.
- **Abort:** a release seen in WR_PUSH, RD_DRAIN or RD_WAIT returns to IDLE with no push. A late `rd_valid_i` is ignored in IDLE.
- **Handshakes:** a FIFO pop happens when `wr_valid_o && wr_ready_i`. A push is refused while full, even if a pop occurs the same cycle. Push and pop in the same non-full cycle leave the level unchanged.
- **Reset:** every output is 0 except `bus_dtack_o` = NAK. The FSM resets to IDLE and the FIFO to empty. A reset in the middle of a transfer discards queued writes.

## Timing
- A CS falling edge reaches `cs_s` after SYNC_STAGES clocks.
- Start-edge cycle E:
  - Write, FIFO not full: push at the end of E+1; `wr_valid_o` and ACK in E+2.
  - Read, FIFO empty: `rd_req_o` in E+1. With `rd_valid_i` in cycle V, ACK and data appear in V+1.
- Release to NAK is 2 clocks after CS rises (first stage, then the registered output).
- Pointers wrap modulo FIFO_DEPTH. Full is `level == FIFO_DEPTH`.

## Structure
- Add to `xosera_pkg` (`xv::`): the FSM state enum `bus_state_t` and the `DTACK_ACK` constant. `DTACK_NAK`, `CS_*` and `RnW_*` already exist there.
- One sub-module, `host_bus_wfifo`: a synchronous FIFO with parameters WIDTH and DEPTH, async reset, and push/pop/full/empty/level.

## Test plan
- **Single write:** write reg 3, byte 1, data 0xA5 with `wr_ready_i`=1 → exactly one pop {3,1,0xA5}; DTACK ACK at E+2; NAK 2 clocks after CS rises.
- **Full FIFO:** with FIFO_DEPTH=4 and `wr_ready_i`=0, issue 5 writes → the fifth holds DTACK NAK; raising `wr_ready_i` → its ACK follows the first pop; entries pop in order.
- **Read ordering:** 2 posted writes then a read of reg 7 → `rd_req_o` only after both pops; `rd_valid_i` with 0x3C 3 cycles later → `bus_data_o`=0x3C, OE=1, ACK.
- **Read timeout:** read with `rd_valid_i` never asserted, RD_TIMEOUT=15 → `rd_timeout_o` pulse, `bus_data_o`=0xFF, ACK.
- **Abort:** release CS during RD_WAIT → IDLE and DTACK NAK; a later `rd_valid_i` → no output change.
- **Reset:** assert `reset_i` asynchronously with 3 queued writes → `fifo_level_o`=0, `wr_valid_o`=0, DTACK NAK immediately with no clock; after release no spurious strobe or edge.

Source files
------------

// File: rtl/host_bus_port_pkg.sv
// Shared definitions for the host bus front end.
// Bus polarity constants and the front-end FSM state type.
package xv;

    localparam logic CS_ENABLED  = 1'b0;
    localparam logic CS_DISABLED = 1'b1;
    localparam logic RnW_WRITE   = 1'b0;
    localparam logic RnW_READ    = 1'b1;
    localparam logic DTACK_NAK   = 1'b0;
    localparam logic DTACK_ACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_PUSH,
        RD_DRAIN,
        RD_WAIT,
        ACK
    } bus_state_t;

endpackage

// File: rtl/host_bus_port_if.sv
// Host bus and register-side signal bundle for host_bus_port.
// master drives the bus inputs; slave is the front end itself.
interface host_bus_port_if #(
    parameter int REG_W      = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic              bus_cs_n_i;
    logic              bus_rd_nwr_i;
    logic [REG_W-1:0]  bus_reg_num_i;
    logic              bus_bytesel_i;
    logic [DATA_W-1:0] bus_data_i;
    logic [DATA_W-1:0] bus_data_o;
    logic              bus_data_oe_o;
    logic              bus_dtack_o;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [REG_W-1:0]  wr_reg_num_o;
    logic              wr_bytesel_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              rd_req_o;
    logic [REG_W-1:0]  rd_reg_num_o;
    logic              rd_bytesel_o;
    logic              rd_valid_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              rd_timeout_o;
    logic [LVL_W-1:0]  fifo_level_o;

    modport master (
        output bus_cs_n_i, bus_rd_nwr_i, bus_reg_num_i,
        output bus_bytesel_i, bus_data_i,
        output wr_ready_i, rd_valid_i, rd_data_i,
        input  bus_data_o, bus_data_oe_o, bus_dtack_o,
        input  wr_valid_o, wr_reg_num_o, wr_bytesel_o, wr_data_o,
        input  rd_req_o, rd_reg_num_o, rd_bytesel_o,
        input  rd_timeout_o, fifo_level_o
    );

    modport slave (
        input  bus_cs_n_i, bus_rd_nwr_i, bus_reg_num_i,
        input  bus_bytesel_i, bus_data_i,
        input  wr_ready_i, rd_valid_i, rd_data_i,
        output bus_data_o, bus_data_oe_o, bus_dtack_o,
        output wr_valid_o, wr_reg_num_o, wr_bytesel_o, wr_data_o,
        output rd_req_o, rd_reg_num_o, rd_bytesel_o,
        output rd_timeout_o, fifo_level_o
    );

endinterface

// File: rtl/host_bus_port_wfifo.sv
// Posted-write FIFO: power-of-2 depth, first-word-fall-through head.
// A push is refused while full even if a pop lands in the same cycle.
module host_bus_wfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/host_bus_port.sv
// Host bus front end: input synchronizers, posted-write FIFO,
// ordered read handshake and internally generated DTACK.
module host_bus_port
    import xv::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int REG_W       = 4,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset_i,
    host_bus_port_if.slave bus
);
    localparam int IN_W  = 3 + REG_W + DATA_W;
    localparam int ENT_W = 1 + REG_W + DATA_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [IN_W-1:0] SYNC_RST =
        {CS_DISABLED, {(IN_W-1){1'b0}}};

    logic [IN_W-1:0]   sync_q [SYNC_STAGES];
    logic [IN_W-1:0]   bus_in;
    logic [IN_W-1:0]   bus_s;
    logic              cs_first;
    logic              cs_s;
    logic              cs_last;
    logic              rd_nwr_s;
    logic [REG_W-1:0]  reg_s;
    logic              bytesel_s;
    logic [DATA_W-1:0] data_s;
    logic              start;
    logic              cs_release;

    bus_state_t        state;
    logic [REG_W-1:0]  t_reg;
    logic              t_bytesel;
    logic [DATA_W-1:0] t_data;
    logic              dtack_q;
    logic              oe_q;
    logic [DATA_W-1:0] rdata_q;
    logic              tmo_q;
    logic [CNT_W-1:0]  cnt;
    logic              tmo_hit;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic [ENT_W-1:0]  head;

    assign bus_in = {bus.bus_cs_n_i, bus.bus_rd_nwr_i, bus.bus_reg_num_i,
                     bus.bus_bytesel_i, bus.bus_data_i};

    // Every stage resets to "deselected" so reset never fakes a CS edge.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            cs_last <= CS_DISABLED;
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cs_last <= cs_s;
        end
    end

    assign bus_s     = sync_q[SYNC_STAGES-1];
    assign cs_s      = bus_s[IN_W-1];
    assign rd_nwr_s  = bus_s[IN_W-2];
    assign reg_s     = bus_s[IN_W-3 -: REG_W];
    assign bytesel_s = bus_s[DATA_W];
    assign data_s    = bus_s[DATA_W-1:0];
    assign cs_first  = sync_q[0][IN_W-1];

    assign start = (state == IDLE) && (cs_last == CS_DISABLED)
                && (cs_s == CS_ENABLED);
    assign cs_release = (cs_first == CS_DISABLED);
    assign tmo_hit = (RD_TIMEOUT != 0)
                  && (cnt == CNT_W'(RD_TIMEOUT - 1));

    assign push = (state == WR_PUSH) && !cs_release && !full;
    assign pop  = !empty && bus.wr_ready_i;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            t_reg     <= '0;
            t_bytesel <= 1'b0;
            t_data    <= '0;
            dtack_q   <= DTACK_NAK;
            oe_q      <= 1'b0;
            rdata_q   <= '0;
            tmo_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        t_reg     <= reg_s;
                        t_bytesel <= bytesel_s;
                        t_data    <= data_s;
                        state     <= (rd_nwr_s == RnW_WRITE) ? WR_PUSH
                                                             : RD_DRAIN;
                    end
                end
                WR_PUSH: begin
                    if (cs_release) begin
                        state <= IDLE;
                    end else if (!full) begin
                        dtack_q <= DTACK_ACK;
                        state   <= ACK;
                    end
                end
                RD_DRAIN: begin
                    if (cs_release) begin
                        state <= IDLE;
                    end else if (empty) begin
                        cnt   <= '0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cs_release) begin
                        state <= IDLE;
                    end else if (bus.rd_valid_i) begin
                        rdata_q <= bus.rd_data_i;
                        dtack_q <= DTACK_ACK;
                        oe_q    <= 1'b1;
                        state   <= ACK;
                    end else if (tmo_hit) begin
                        rdata_q <= '1;
                        tmo_q   <= 1'b1;
                        dtack_q <= DTACK_ACK;
                        oe_q    <= 1'b1;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (cs_release) begin
                        dtack_q <= DTACK_NAK;
                        oe_q    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    host_bus_wfifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk   (clk),
        .rst   (reset_i),
        .push  (push),
        .wdata ({t_reg, t_bytesel, t_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Read request fires in the drain-exit cycle, once the last pop is done.
    assign bus.rd_req_o = (state == RD_DRAIN) && !cs_release && empty;

    assign bus.bus_data_o    = rdata_q;
    assign bus.bus_data_oe_o = oe_q;
    assign bus.bus_dtack_o   = dtack_q;
    assign bus.rd_timeout_o  = tmo_q;
    assign bus.rd_reg_num_o  = t_reg;
    assign bus.rd_bytesel_o  = t_bytesel;
    assign bus.wr_valid_o    = !empty;
    assign bus.fifo_level_o  = level;
    assign {bus.wr_reg_num_o, bus.wr_bytesel_o, bus.wr_data_o} = head;

endmodule

// File: tb/tb_host_bus_port.sv
// Randomized bench for host_bus_port against a queue-based host/register
// model: posted-write order, read ordering, timeout, abort and reset.
module tb_host_bus_port;
    import xv::*;

    localparam int SYNC_STAGES = 2;
    localparam int REG_W       = 4;
    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int RD_TIMEOUT  = 15;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    host_bus_port_if #(
        .REG_W      (REG_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bif ();

    host_bus_port #(
        .SYNC_STAGES (SYNC_STAGES),
        .REG_W       (REG_W),
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .RD_TIMEOUT  (RD_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bif)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_pop = 0;
    int          ready_mode = 1;
    logic [12:0] exp_q [$];
    logic [7:0]  last_rd = 8'h00;
    logic        mon_rdy;
    logic [12:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Register side: drives wr_ready and checks every pop against the queue.
    always begin
        @(negedge clk);
        #1;
        case (ready_mode)
            0:       mon_rdy = 1'b0;
            1:       mon_rdy = 1'b1;
            default: mon_rdy = 1'($urandom % 2);
        endcase
        bif.wr_ready_i = mon_rdy;
        if (!reset_i) begin
            if (bif.rd_req_o)
                check("rd_order", 32'(exp_q.size()), 32'd0);
            if (bif.wr_valid_o && mon_rdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_extra", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_head",
                          {19'd0, bif.wr_reg_num_o, bif.wr_bytesel_o,
                           bif.wr_data_o},
                          {19'd0, mon_e});
                    n_pop++;
                end
            end
        end
    end

    task automatic wait_ack(input int lim, output int cyc);
        cyc = 0;
        while (bif.bus_dtack_o != DTACK_ACK && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_req(input int lim, output int cyc);
        cyc = 0;
        while (!bif.rd_req_o && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        check("rd_req_seen", 32'(bif.rd_req_o), 32'd1);
    endtask

    task automatic drain(input int lim);
        int cyc = 0;
        while (bif.fifo_level_o != 0 && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        check("drain", 32'(bif.fifo_level_o), 32'd0);
    endtask

    task automatic drive_write(input logic [3:0] r, input logic b,
                               input logic [7:0] d);
        bif.bus_rd_nwr_i  = RnW_WRITE;
        bif.bus_reg_num_i = r;
        bif.bus_bytesel_i = b;
        bif.bus_data_i    = d;
        bif.bus_cs_n_i    = CS_ENABLED;
        exp_q.push_back({r, b, d});
    endtask

    task automatic drive_read(input logic [3:0] r, input logic b);
        bif.bus_rd_nwr_i  = RnW_READ;
        bif.bus_reg_num_i = r;
        bif.bus_bytesel_i = b;
        bif.bus_data_i    = 8'($urandom);
        bif.bus_cs_n_i    = CS_ENABLED;
    endtask

    task automatic host_write(input logic [3:0] r, input logic b,
                              input logic [7:0] d, input int exp_lat);
        int cyc;
        drive_write(r, b, d);
        wait_ack(300, cyc);
        check("wr_ack", 32'(bif.bus_dtack_o), 32'(DTACK_ACK));
        if (exp_lat > 0) check("wr_ack_lat", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic host_release();
        bif.bus_cs_n_i = CS_DISABLED;
        @(negedge clk);
        check("rel_hold", 32'(bif.bus_dtack_o), 32'(DTACK_ACK));
        @(negedge clk);
        check("rel_nak", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("rel_oe", 32'(bif.bus_data_oe_o), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic host_read(input logic [3:0] r, input logic b,
                             input logic [7:0] d, input int lat,
                             input bit chk_lat);
        int cyc;
        drive_read(r, b);
        wait_req(300, cyc);
        if (chk_lat) check("rd_req_lat", 32'(cyc), 32'(SYNC_STAGES + 1));
        check("rd_after_drain", 32'(exp_q.size()), 32'd0);
        check("rd_target", {27'd0, bif.rd_reg_num_o, bif.rd_bytesel_o},
              {27'd0, r, b});
        @(negedge clk);
        check("rd_req_pulse", 32'(bif.rd_req_o), 32'd0);
        repeat (lat - 1) @(negedge clk);
        check("rd_hold", {27'd0, bif.rd_reg_num_o, bif.rd_bytesel_o},
              {27'd0, r, b});
        bif.rd_data_i  = d;
        bif.rd_valid_i = 1'b1;
        @(negedge clk);
        bif.rd_valid_i = 1'b0;
        check("rd_ack", 32'(bif.bus_dtack_o), 32'(DTACK_ACK));
        check("rd_data", 32'(bif.bus_data_o), 32'(d));
        check("rd_oe", 32'(bif.bus_data_oe_o), 32'd1);
        last_rd = d;
    endtask

    initial begin
        int cyc;
        int p0;
        int bad;
        reset_i           = 1'b1;
        bif.bus_cs_n_i    = CS_DISABLED;
        bif.bus_rd_nwr_i  = RnW_WRITE;
        bif.bus_reg_num_i = '0;
        bif.bus_bytesel_i = 1'b0;
        bif.bus_data_i    = '0;
        bif.rd_valid_i    = 1'b0;
        bif.rd_data_i     = '0;

        #12;
        check("rst_dtack", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("rst_level", 32'(bif.fifo_level_o), 32'd0);
        check("rst_wvalid", 32'(bif.wr_valid_o), 32'd0);
        check("rst_outs", {bif.bus_data_o, 6'd0, bif.bus_data_oe_o,
                           bif.rd_req_o, bif.rd_timeout_o},
              32'd0);
        @(negedge clk);
        #2 reset_i = 1'b0;
        @(negedge clk);

        // single write
        ready_mode = 1;
        p0 = n_pop;
        host_write(4'h3, 1'b1, 8'hA5, SYNC_STAGES + 2);
        check("wr_valid_at_ack", 32'(bif.wr_valid_o), 32'd1);
        host_release();
        drain(50);
        check("single_pops", 32'(n_pop - p0), 32'd1);

        // fill the FIFO, fifth write waits for the first pop
        ready_mode = 0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            host_write(4'(i + 1), 1'(i), 8'(8'h10 + i), 0);
            host_release();
        end
        check("full_level", 32'(bif.fifo_level_o), 32'(FIFO_DEPTH));
        drive_write(4'h5, 1'b0, 8'h55);
        repeat (8) @(negedge clk);
        check("full_wait", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("full_hold", 32'(bif.fifo_level_o), 32'(FIFO_DEPTH));
        ready_mode = 1;
        wait_ack(50, cyc);
        check("full_ack", 32'(bif.bus_dtack_o), 32'(DTACK_ACK));
        check("full_ack_lat", 32'(cyc), 32'd2);
        host_release();
        drain(50);
        check("full_q_empty", 32'(exp_q.size()), 32'd0);

        // read stays behind two posted writes
        ready_mode = 0;
        p0 = n_pop;
        host_write(4'h2, 1'b0, 8'h11, 0);
        host_release();
        host_write(4'h4, 1'b1, 8'h22, 0);
        host_release();
        fork
            begin
                repeat (6) @(negedge clk);
                ready_mode = 1;
            end
            host_read(4'h7, 1'b0, 8'h3C, 3, 1'b0);
        join
        check("order_pops", 32'(n_pop - p0), 32'd2);
        host_release();

        // read timeout
        drive_read(4'h2, 1'b1);
        wait_req(300, cyc);
        check("tmo_req_lat", 32'(cyc), 32'(SYNC_STAGES + 1));
        wait_ack(60, cyc);
        check("tmo_ack", 32'(bif.bus_dtack_o), 32'(DTACK_ACK));
        check("tmo_lat", 32'(cyc), 32'(RD_TIMEOUT + 1));
        check("tmo_pulse", 32'(bif.rd_timeout_o), 32'd1);
        check("tmo_data", 32'(bif.bus_data_o), 32'hFF);
        check("tmo_oe", 32'(bif.bus_data_oe_o), 32'd1);
        last_rd = 8'hFF;
        @(negedge clk);
        check("tmo_one_cycle", 32'(bif.rd_timeout_o), 32'd0);
        host_release();

        // abort during RD_WAIT, then a late rd_valid
        drive_read(4'h9, 1'b0);
        wait_req(300, cyc);
        repeat (2) @(negedge clk);
        bif.bus_cs_n_i = CS_DISABLED;
        repeat (3) @(negedge clk);
        check("abort_nak", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("abort_oe", 32'(bif.bus_data_oe_o), 32'd0);
        bif.rd_data_i  = 8'h99;
        bif.rd_valid_i = 1'b1;
        @(negedge clk);
        bif.rd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("late_data", 32'(bif.bus_data_o), 32'(last_rd));
        check("late_nak", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("late_oe", 32'(bif.bus_data_oe_o), 32'd0);

        // randomized mix of writes and reads
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                host_write(4'($urandom), 1'($urandom), 8'($urandom), 0);
            end else begin
                host_read(4'($urandom), 1'($urandom), 8'($urandom),
                          $urandom_range(1, 5), 1'b0);
            end
            host_release();
        end
        drain(200);
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // async reset with queued writes and one in flight
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            host_write(4'(i + 8), 1'b1, 8'(8'hC0 + i), 0);
            host_release();
        end
        check("rst_pre_level", 32'(bif.fifo_level_o), 32'd3);
        drive_write(4'hE, 1'b1, 8'h77);
        repeat (2) @(negedge clk);
        #2;
        reset_i        = 1'b1;
        bif.bus_cs_n_i = CS_DISABLED;
        #1;
        check("arst_level", 32'(bif.fifo_level_o), 32'd0);
        check("arst_wvalid", 32'(bif.wr_valid_o), 32'd0);
        check("arst_dtack", 32'(bif.bus_dtack_o), 32'(DTACK_NAK));
        check("arst_outs", {bif.bus_data_o, 6'd0, bif.bus_data_oe_o,
                            bif.rd_req_o, bif.rd_timeout_o},
              32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset_i = 1'b0;
        ready_mode = 1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bif.bus_dtack_o != DTACK_NAK || bif.wr_valid_o ||
                bif.rd_req_o)
                bad++;
        end
        check("rst_quiet", 32'(bad), 32'd0);
        p0 = n_pop;
        host_write(4'h1, 1'b0, 8'h5A, SYNC_STAGES + 2);
        host_release();
        drain(50);
        check("post_rst_pops", 32'(n_pop - p0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
